cursor_overlay: RTL and testbench

Parametrised multi-cursor overlay for the VGA pixel path. Compares each pixel coordinate against up to `NUM_CURSORS` cursor channels, each with its own frame-latched position, size, shape and colour, plus optional blink. The winning cursor's colour replaces the background RGB, in a fixed 2-cycle pipeline. It sits between the background/sprite colour mapper and the VGA DAC outputs.

---
 rtl/cursor_pkg.sv | 21 ++
 rtl/cursor_shape_hit.sv | 35 +++
 rtl/cursor_overlay.sv | 198 +++++++++++++++++++
 tb/tb_cursor_overlay.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared shape/colour types and parameter defaults for the cursor overlay
package cursor_pkg;

  typedef enum logic [1:0] {
    DIAMOND = 2'd0,
    SQUARE  = 2'd1,
    CROSS   = 2'd2,
    RING    = 2'd3
  } shape_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int DEF_NUM_CURSORS  = 2;
  localparam int DEF_COORD_W      = 10;
  localparam int DEF_BLINK_FRAMES = 30;

endpackage

// File: rtl/cursor_shape_hit.sv
// rtl/cursor_shape_hit.sv - combinational shape test for one cursor channel
module cursor_shape_hit
  import cursor_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic [COORD_W-1:0] adx,
  input  logic [COORD_W-1:0] ady,
  input  logic [COORD_W-1:0] size,
  input  shape_t             shape,
  output logic               hit
);

  logic [COORD_W:0]   sum;
  logic [COORD_W:0]   sz;
  logic [COORD_W:0]   ring_lo;
  logic [COORD_W-1:0] mx;

  always_comb begin
    sum     = {1'b0, adx} + {1'b0, ady};
    sz      = {1'b0, size};
    mx      = (adx > ady) ? adx : ady;
    // ring inner edge is size-1, held at 0 so size 0 still marks the centre
    ring_lo = (size == '0) ? '0 : sz - (COORD_W+1)'(1);
    hit     = 1'b0;
    case (shape)
      DIAMOND: hit = (sum <= sz);
      SQUARE:  hit = (mx <= size);
      CROSS:   hit = ((adx == '0) || (ady == '0)) && (mx <= size);
      RING:    hit = (sum <= sz) && (sum >= ring_lo);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/cursor_overlay.sv
// rtl/cursor_overlay.sv - multi-cursor overlay, 2-cycle pixel pipeline
// Optional blink gate built when CURSOR_BLINK_EN is defined.
module cursor_overlay
  import cursor_pkg::*;
#(
  parameter int  NUM_CURSORS  = DEF_NUM_CURSORS,
  parameter int  COORD_W      = DEF_COORD_W,
  parameter int  BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int IDX_W        = (NUM_CURSORS > 1) ? $clog2(NUM_CURSORS) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic                           blank,
  input  logic [3:0]                     bg_red,
  input  logic [3:0]                     bg_green,
  input  logic [3:0]                     bg_blue,
  input  logic [NUM_CURSORS-1:0]         cur_en,
  input  logic [NUM_CURSORS*COORD_W-1:0] cur_x,
  input  logic [NUM_CURSORS*COORD_W-1:0] cur_y,
  input  logic [NUM_CURSORS*COORD_W-1:0] cur_size,
  input  logic [NUM_CURSORS*2-1:0]       cur_shape,
  input  logic [NUM_CURSORS*12-1:0]      cur_color,
  output logic [3:0]                     Red,
  output logic [3:0]                     Green,
  output logic [3:0]                     Blue,
  output logic                           hit_any,
  output logic [IDX_W-1:0]               hit_idx
);

  localparam int N = NUM_CURSORS;

  logic [N-1:0]       sh_en;
  logic [COORD_W-1:0] sh_x     [N];
  logic [COORD_W-1:0] sh_y     [N];
  logic [COORD_W-1:0] sh_size  [N];
  shape_t             sh_shape [N];
  rgb444_t            sh_color [N];
  logic               vis;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_en <= '0;
      for (int i = 0; i < N; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_size[i]  <= '0;
        sh_shape[i] <= DIAMOND;
        sh_color[i] <= '0;
      end
    end else if (frame_start) begin
      sh_en <= cur_en;
      for (int i = 0; i < N; i++) begin
        sh_x[i]     <= cur_x[i*COORD_W +: COORD_W];
        sh_y[i]     <= cur_y[i*COORD_W +: COORD_W];
        sh_size[i]  <= cur_size[i*COORD_W +: COORD_W];
        sh_shape[i] <= shape_t'(cur_shape[2*i +: 2]);
        sh_color[i] <= rgb444_t'(cur_color[12*i +: 12]);
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // phase 1 = visible; it flips each time the counter wraps
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  assign vis = blink_phase;
`else
  // gate is permanently open; BLINK_FRAMES has no effect in this build
  assign vis = 1'b1 | (BLINK_FRAMES == 0);
`endif

  logic [COORD_W:0]   dx  [N];
  logic [COORD_W:0]   dy  [N];
  logic [COORD_W-1:0] adx [N];
  logic [COORD_W-1:0] ady [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dx[i]  = {1'b0, DrawX} - {1'b0, sh_x[i]};
      dy[i]  = {1'b0, DrawY} - {1'b0, sh_y[i]};
      adx[i] = dx[i][COORD_W] ? COORD_W'(-dx[i]) : dx[i][COORD_W-1:0];
      ady[i] = dy[i][COORD_W] ? COORD_W'(-dy[i]) : dy[i][COORD_W-1:0];
    end
  end

  // stage 1 also snapshots the per-channel shadow state so a frame_start
  // landing between the two stages cannot mix old and new cursor settings
  logic [COORD_W-1:0] s1_adx   [N];
  logic [COORD_W-1:0] s1_ady   [N];
  logic [COORD_W-1:0] s1_size  [N];
  shape_t             s1_shape [N];
  rgb444_t            s1_color [N];
  logic [N-1:0]       s1_act;
  logic               s1_blank;
  rgb444_t            s1_bg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_act   <= '0;
      s1_blank <= 1'b0;
      s1_bg    <= '0;
      for (int i = 0; i < N; i++) begin
        s1_adx[i]   <= '0;
        s1_ady[i]   <= '0;
        s1_size[i]  <= '0;
        s1_shape[i] <= DIAMOND;
        s1_color[i] <= '0;
      end
    end else begin
      s1_act   <= sh_en & {N{vis}};
      s1_blank <= blank;
      s1_bg    <= {bg_red, bg_green, bg_blue};
      for (int i = 0; i < N; i++) begin
        s1_adx[i]   <= adx[i];
        s1_ady[i]   <= ady[i];
        s1_size[i]  <= sh_size[i];
        s1_shape[i] <= sh_shape[i];
        s1_color[i] <= sh_color[i];
      end
    end
  end

  logic [N-1:0] shape_ok;
  logic [N-1:0] hit;

  for (genvar i = 0; i < N; i++) begin : g_hit
    cursor_shape_hit #(
      .COORD_W(COORD_W)
    ) u_hit (
      .adx  (s1_adx[i]),
      .ady  (s1_ady[i]),
      .size (s1_size[i]),
      .shape(s1_shape[i]),
      .hit  (shape_ok[i])
    );
  end

  assign hit = s1_act & shape_ok;

  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  rgb444_t          win_col;

  // descending scan so the lowest-index hit is the last write
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_col = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_col = s1_color[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {Red, Green, Blue} <= '0;
      hit_any            <= 1'b0;
      hit_idx            <= '0;
    end else if (!s1_blank) begin
      {Red, Green, Blue} <= '0;
      hit_any            <= 1'b0;
      hit_idx            <= '0;
    end else if (win_hit) begin
      {Red, Green, Blue} <= win_col;
      hit_any            <= 1'b1;
      hit_idx            <= win_idx;
    end else begin
      {Red, Green, Blue} <= s1_bg;
      hit_any            <= 1'b0;
      hit_idx            <= '0;
    end
  end

endmodule

// File: tb/tb_cursor_overlay.sv
// tb/tb_cursor_overlay.sv - randomized + directed bench for cursor_overlay against a behavioural model
module tb_cursor_overlay;

  localparam int N  = 2;
  localparam int W  = 10;
  localparam int BF = 2;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           frame_start = 1'b0;
  logic [W-1:0]   DrawX = '0;
  logic [W-1:0]   DrawY = '0;
  logic           blank = 1'b0;
  logic [3:0]     bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [N-1:0]   cur_en = '0;
  logic [N*W-1:0] cur_x = '0, cur_y = '0, cur_size = '0;
  logic [N*2-1:0] cur_shape = '0;
  logic [N*12-1:0] cur_color = '0;
  logic [3:0]     Red, Green, Blue;
  logic           hit_any;
  logic [0:0]     hit_idx;

  cursor_overlay #(
    .NUM_CURSORS (N),
    .COORD_W     (W),
    .BLINK_FRAMES(BF)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .bg_red     (bg_red),
    .bg_green   (bg_green),
    .bg_blue    (bg_blue),
    .cur_en     (cur_en),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .cur_size   (cur_size),
    .cur_shape  (cur_shape),
    .cur_color  (cur_color),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .hit_any    (hit_any),
    .hit_idx    (hit_idx)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the frame-latched cursor state and number of frame_starts since reset
  bit m_en  [N];
  int m_x   [N];
  int m_y   [N];
  int m_sz  [N];
  int m_sh  [N];
  int m_col [N];
  int nfs;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (hit_any,hit_idx,RGB)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {18'd0, hit_any, hit_idx, Red, Green, Blue};
  endfunction

  function automatic bit in_shape(int adx, int ady, int sz, int sh);
    int s  = adx + ady;
    int mx = (adx > ady) ? adx : ady;
    case (sh)
      0:       return s <= sz;
      1:       return mx <= sz;
      2:       return (adx == 0 || ady == 0) && mx <= sz;
      default: return (s <= sz) && (s >= ((sz > 0) ? sz - 1 : 0));
    endcase
  endfunction

  function automatic logic [31:0] model_pixel(int px, int py, bit blk, logic [11:0] bg);
    bit vis;
    if (!blk) return 32'd0;
`ifdef CURSOR_BLINK_EN
    vis = ((nfs / BF) % 2) == 0;
`else
    vis = 1'b1;
`endif
    if (vis) begin
      for (int i = 0; i < N; i++) begin
        int dx  = px - m_x[i];
        int dy  = py - m_y[i];
        int adx = (dx < 0) ? -dx : dx;
        int ady = (dy < 0) ? -dy : dy;
        if (m_en[i] && in_shape(adx, ady, m_sz[i], m_sh[i]))
          return 32'(8192 + i * 4096 + m_col[i]);
      end
    end
    return {20'd0, bg};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sz[i] = 0; m_sh[i] = 0; m_col[i] = 0;
    end
    nfs = 0;
  endtask

  task automatic load_model();
    for (int i = 0; i < N; i++) begin
      m_en[i]  = cur_en[i];
      m_x[i]   = int'(cur_x[i*W +: W]);
      m_y[i]   = int'(cur_y[i*W +: W]);
      m_sz[i]  = int'(cur_size[i*W +: W]);
      m_sh[i]  = int'(cur_shape[2*i +: 2]);
      m_col[i] = int'(cur_color[12*i +: 12]);
    end
    nfs++;
  endtask

  task automatic set_cur(input int i, input bit en, input int x, input int y,
                         input int sz, input int sh, input int col);
    cur_en[i]             = en;
    cur_x[i*W +: W]       = x[W-1:0];
    cur_y[i*W +: W]       = y[W-1:0];
    cur_size[i*W +: W]    = sz[W-1:0];
    cur_shape[2*i +: 2]   = sh[1:0];
    cur_color[12*i +: 12] = col[11:0];
  endtask

  // present one pixel; its result is checked two edges later
  task automatic step(input string tag, input int x, input int y, input bit blk,
                      input bit fs, input logic [11:0] bg);
    DrawX = x[W-1:0];
    DrawY = y[W-1:0];
    blank = blk;
    {bg_red, bg_green, bg_blue} = bg;
    frame_start = fs;
    exp_q.push_back(model_pixel(x, y, blk, bg));
    tag_q.push_back(tag);
    if (fs) load_model();
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    if (exp_q.size() == 2) check(tag_q.pop_front(), obs(), exp_q.pop_front());
  endtask

  task automatic mid_reset();
    #2 Reset = 1'b1;
    #1 check("reset_async", obs(), 32'd0);
    exp_q.delete();
    tag_q.delete();
    reset_model();
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  function automatic int clampc(int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", obs(), 32'd0);
    Reset = 1'b0;

    set_cur(0, 1, 100, 100, 5, 0, 'hFFF);
    set_cur(1, 0, 0, 0, 0, 0, 0);
    step("fs_old_shadow", 103, 102, 1, 1, 'h123);
    step("diamond_in",    103, 102, 1, 0, 'h123);
    step("diamond_out",   104, 102, 1, 0, 'h123);

    set_cur(0, 1, 100, 100, 5, 1, 'hFFF);
    step("fs_square",     0, 0, 1, 1, 'h123);
    step("square_in",     105, 95, 1, 0, 'h123);
    step("square_out",    106, 100, 1, 0, 'h123);

    set_cur(0, 1, 100, 100, 5, 2, 'hFFF);
    step("fs_cross",      0, 0, 1, 1, 'h123);
    step("cross_in",      100, 95, 1, 0, 'h123);
    step("cross_out",     101, 99, 1, 0, 'h123);

    set_cur(0, 1, 50, 50, 4, 3, 'hABC);
    step("fs_ring",       0, 0, 1, 1, 'h456);
    step("ring_outer",    54, 50, 1, 0, 'h456);
    step("ring_inner",    53, 50, 1, 0, 'h456);
    step("ring_hole",     52, 50, 1, 0, 'h456);
    step("ring_centre",   50, 50, 1, 0, 'h456);

    set_cur(0, 1, 50, 50, 0, 3, 'hABC);
    step("fs_size0",      0, 0, 1, 1, 'h456);
    step("size0_centre",  50, 50, 1, 0, 'h456);
    step("size0_side",    51, 50, 1, 0, 'h456);

    set_cur(0, 1, 1, 1, 5, 0, 'h777);
    step("fs_edge",       0, 0, 1, 1, 'h456);
    step("nowrap_far",    1023, 1, 1, 0, 'h456);
    step("edge_in",       0, 0, 1, 0, 'h456);

    set_cur(0, 1, 200, 200, 3, 1, 'hF00);
    set_cur(1, 1, 200, 200, 3, 1, 'h0F0);
    step("fs_overlap",    0, 0, 1, 1, 'h123);
    step("prio_ch0",      200, 200, 1, 0, 'h123);
    cur_en[0] = 1'b0;
    step("fs_dis0",       0, 0, 1, 1, 'h123);
    step("prio_ch1",      200, 200, 1, 0, 'h123);

    set_cur(1, 1, 300, 200, 3, 1, 'h0F0);
    step("midframe_hold", 200, 200, 1, 0, 'h123);
    step("fs_same_cycle", 200, 200, 1, 1, 'h123);
    step("new_pos_old",   200, 200, 1, 0, 'h123);
    step("new_pos_hit",   300, 200, 1, 0, 'h123);
    step("blank_over",    300, 200, 0, 0, 'h123);
    step("pre_reset",     300, 200, 1, 0, 'h123);
    mid_reset();
    step("post_reset_a",  300, 200, 1, 0, 'h321);
    step("post_reset_b",  300, 200, 1, 0, 'h321);
    step("post_reset_c",  300, 200, 1, 0, 'h321);

`ifdef CURSOR_BLINK_EN
    for (int f = 0; f < 7; f++) begin
      step("blink_fs",    0, 0, 1, 1, 'h111);
      step("blink_pix",   300, 200, 1, 0, 'h111);
      step("blink_pix2",  301, 200, 1, 0, 'h111);
    end
`endif

    for (int k = 0; k < 600; k++) begin
      bit fs;
      int c, px, py;
      fs = (k == 0) || ($urandom_range(0, 29) == 0);
      if (fs) begin
        for (int i = 0; i < N; i++)
          set_cur(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4095));
      end else if ($urandom_range(0, 19) == 0) begin
        set_cur($urandom_range(0, N - 1), 1, $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4095));
      end
      c  = $urandom_range(0, N - 1);
      px = clampc(m_x[c] + int'($urandom_range(0, 30)) - 15);
      py = clampc(m_y[c] + int'($urandom_range(0, 30)) - 15);
      step("random", px, py, $urandom_range(0, 9) != 0, fs, 12'($urandom_range(0, 4095)));
    end

    step("drain", 0, 0, 0, 0, 'h000);
    step("drain", 0, 0, 0, 0, 'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
